// File: rtl/uart_pkg.sv
// Shared UART receive definitions: receiver state encoding, default bit
// period and frame width. Also used by the downstream sample assembler.
//
// Build option: UART_RX_PARITY_EN adds the PARITY state (8E1 framing).
package uart_pkg;

  // 100 MHz system clock at 115200 Bd.
  localparam int unsigned CLKS_PER_BIT_DEF = 868;

  // Data bits per UART frame.
  localparam int unsigned FRAME_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial input.
// Both flops reset to 1 so that an idle line is seen after reset.
//
// Ports:
//   in_clk    system clock
//   in_rst    synchronous, active-high reset
//   in_async  asynchronous input
//   out_sync  synchronized output, two clock cycles behind in_async
module uart_rx_sync (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_async,
  output logic out_sync
);

  logic meta_q;
  logic sync_q;

  // NOTE: sequential state is written only with non-blocking assignments,
  // so every flop samples the values from before the clock edge.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= in_async;
      sync_q <= meta_q;
    end
  end

  assign out_sync = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (8E1 when UART_RX_PARITY_EN is defined), LSB first.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit, 4..65535
// Ports:
//   in_clk          system clock
//   in_rst          synchronous, active-high reset
//   in_uart_rx      asynchronous serial line, idle high
//   out_uart_frame  last correctly received byte, held until the next one
//   out_uart_ready  one-cycle pulse, out_uart_frame valid in the same cycle
//   out_frame_err   one-cycle pulse when the stop bit is sampled low
//   out_parity_err  one-cycle pulse on even-parity mismatch (0 without parity)
//
// Build option: UART_RX_PARITY_EN enables the parity bit and its check.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic               in_clk,
  input  logic               in_rst,
  input  logic               in_uart_rx,
  output logic [FRAME_W-1:0] out_uart_frame,
  output logic               out_uart_ready,
  output logic               out_frame_err,
  output logic               out_parity_err
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned BIT_W = $clog2(FRAME_W);

  // The start-bit sample point is pulled in by two cycles: one cycle is
  // spent registering the falling edge into START, the other registering
  // the result pulse. This puts out_uart_ready exactly half a bit plus
  // nine bits after the synchronized line first goes low.
  localparam logic [CNT_W-1:0] START_SAMPLE = CNT_W'(CLKS_PER_BIT / 2 - 2);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA    = BIT_W'(FRAME_W - 1);

  logic rx_sync;
  logic rx_hist_q;

  rx_state_e          state_q, state_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [BIT_W-1:0]   bit_q, bit_n;
  logic [FRAME_W-1:0] shift_q, shift_n;
  logic [FRAME_W-1:0] frame_q, frame_n;
  logic               ready_q, ready_n;
  logic               ferr_q, ferr_n;
  logic               par_bad;
`ifdef UART_RX_PARITY_EN
  logic               par_q, par_n;
  logic               perr_q, perr_n;
`endif

  uart_rx_sync u_sync (
    .in_clk   (in_clk),
    .in_rst   (in_rst),
    .in_async (in_uart_rx),
    .out_sync (rx_sync)
  );

`ifdef UART_RX_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_bad = ^{shift_q, par_q};
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      rx_hist_q <= 1'b1;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      frame_q   <= '0;
      ready_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_hist_q <= rx_sync;
      state_q   <= state_n;
      cnt_q     <= cnt_n;
      bit_q     <= bit_n;
      shift_q   <= shift_n;
      frame_q   <= frame_n;
      ready_q   <= ready_n;
      ferr_q    <= ferr_n;
`ifdef UART_RX_PARITY_EN
      par_q     <= par_n;
      perr_q    <= perr_n;
`endif
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_n = state_q;
    cnt_n   = cnt_q + 1'b1;
    bit_n   = bit_q;
    shift_n = shift_q;
    frame_n = frame_q;
    ready_n = 1'b0;
    ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_q;
    perr_n  = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        cnt_n = '0;
        // Only a high-to-low transition starts a frame, so a line stuck
        // low (break) cannot retrigger.
        if (rx_hist_q && !rx_sync) begin
          state_n = ST_START;
          bit_n   = '0;
        end
      end

      ST_START: begin
        if (cnt_q == START_SAMPLE) begin
          cnt_n   = '0;
          state_n = rx_sync ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          shift_n = {rx_sync, shift_q[FRAME_W-1:1]};
          bit_n   = bit_q + 1'b1;
          if (bit_q == LAST_DATA) begin
`ifdef UART_RX_PARITY_EN
            state_n = ST_PARITY;
`else
            state_n = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          par_n   = rx_sync;
          state_n = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_n   = '0;
          state_n = ST_IDLE;
          // A missing stop bit takes precedence over a parity mismatch so
          // that only one pulse is ever raised per frame.
          if (!rx_sync) begin
            ferr_n = 1'b1;
          end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
            perr_n = 1'b1;
`endif
          end else begin
            frame_n = shift_q;
            ready_n = 1'b1;
          end
        end
      end

      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign out_uart_frame = frame_q;
  assign out_uart_ready = ready_q;
  assign out_frame_err  = ferr_q;
`ifdef UART_RX_PARITY_EN
  assign out_parity_err = perr_q;
`else
  assign out_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16.
// The driver serialises frames bit by bit and, at the moment it starts a
// frame, pushes the outcome a receiver must report (kind, byte held on
// out_uart_frame, cycle of the pulse) into a queue. A monitor on the
// falling clock edge pops one entry for every pulse the DUT raises.
module tb_uart_rx;

  localparam int C = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  // Two clocks through the synchronizer, then half a bit plus the
  // remaining bits of the frame.
  localparam int LAT = 2 + C / 2 + 9 * C + (PAR ? C : 0);

  localparam int EV_READY = 0;
  localparam int EV_FERR  = 1;
  localparam int EV_PERR  = 2;

  typedef struct {
    int         kind;
    logic [7:0] frame;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] frame;
  logic       ready;
  logic       ferr;
  logic       perr;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .in_clk         (clk),
    .in_rst         (rst),
    .in_uart_rx     (rx),
    .out_uart_frame (frame),
    .out_uart_ready (ready),
    .out_frame_err  (ferr),
    .out_parity_err (perr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference state: the byte a correct receiver is holding.
  logic [7:0] model_frame = 8'h00;

  // Monitor: every pulse must match the oldest outstanding expectation.
  int         hot;
  int         act_kind;
  exp_t       e;
  logic [23:0] asm_word = '0;

  always @(negedge clk) begin
    hot = int'(ready) + int'(ferr) + int'(perr);
    if (hot > 1) begin
      check("one_pulse_at_a_time", hot, 1);
    end else if (hot == 1) begin
      act_kind = ready ? EV_READY : (ferr ? EV_FERR : EV_PERR);
      if (ready) asm_word = {frame, asm_word[23:8]};
      if (exp_q.size() == 0) begin
        check("unexpected_pulse_kind", act_kind, 99);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", act_kind, e.kind);
        check("pulse_cycle", cyc, e.cyc);
        check("frame_value", frame, e.frame);
      end
    end
  end

  // All driver tasks start and end 1 time unit after a rising edge.
  task automatic hold(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
    exp_t x;
    if (!stop) begin
      x.kind = EV_FERR;
    end else if (PAR && ((^d) ^ par)) begin
      x.kind = EV_PERR;
    end else begin
      x.kind      = EV_READY;
      model_frame = d;
    end
    x.frame = model_frame;
    x.cyc   = cyc + LAT;
    exp_q.push_back(x);
    hold(1'b0, C);
    for (int i = 0; i < 8; i++) hold(d[i], C);
    if (PAR) hold(par, C);
    hold(stop, C);
  endtask

  initial begin
    logic [7:0] d;
    logic       stop;
    logic       par;
    int         gap;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_frame", frame, 8'h00);
    check("reset_pulses", {ready, ferr, perr}, 3'b000);
    hold(1'b1, 4);

    // Single byte, latency checked by the monitor.
    send_frame(8'hA5, 1'b1, ^8'hA5);
    hold(1'b1, 2 * C);

    // Short low glitch: must be discarded, then a normal byte.
    hold(1'b0, 4);
    hold(1'b1, 2 * C);
    send_frame(8'h3C, 1'b1, ^8'h3C);
    hold(1'b1, 2 * C);

    // Missing stop bit, break held low, then a normal byte.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    hold(1'b0, 40);
    hold(1'b1, 2 * C);
    send_frame(8'h5A, 1'b1, ^8'h5A);
    hold(1'b1, 2 * C);

    // Back-to-back frames assembled into a 24-bit sample.
    asm_word = '0;
    send_frame(8'h01, 1'b1, ^8'h01);
    send_frame(8'h02, 1'b1, ^8'h02);
    send_frame(8'h03, 1'b1, ^8'h03);
    hold(1'b1, 2 * C);
    check("assembled_sample", asm_word, 24'h030201);

    // Reset in the middle of 0xFF after data bit 3.
    hold(1'b0, C);
    for (int i = 0; i < 4; i++) hold(1'b1, C);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst         = 1'b0;
    model_frame = 8'h00;
    check("mid_frame_reset_frame", frame, 8'h00);
    hold(1'b1, 5 * C);
    check("after_reset_frame", frame, 8'h00);
    send_frame(8'hFF, 1'b1, ^8'hFF);
    hold(1'b1, 2 * C);

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b0);
    hold(1'b1, 2 * C);
    send_frame(8'h07, 1'b1, 1'b1);
    hold(1'b1, 2 * C);
`endif

    // Random bytes, occasional bad stop/parity bits, random gaps
    // including back-to-back frames.
    for (int n = 0; n < 30; n++) begin
      d    = 8'($urandom);
      stop = ($urandom_range(0, 5) != 0);
      par  = (^d) ^ ($urandom_range(0, 4) == 0);
      send_frame(d, stop, par);
      if (!stop) begin
        hold(1'b0, $urandom_range(0, 40));
        hold(1'b1, C + $urandom_range(0, C));
      end else begin
        gap = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 2 * C);
        if (gap > 0) hold(1'b1, gap);
      end
    end
    hold(1'b1, 2 * C);

    for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(posedge clk);
    check("outstanding_expectations", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
